// File: rtl/alu_exec_if.sv
// alu_exec_if: request/result bus of the ALU execution unit.
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. A source
// holds its payload stable while valid is high and ready is low.
//
// Signals (master = requester/consumer, slave = execution unit):
//   in_valid, in_ready            request handshake
//   ALUOp, Funct, Opcode, a, b    request payload
//   out_valid, out_ready          result handshake
//   result, zero, ovf, illegal,   result payload
//   alu_ctrl
interface alu_exec_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       ALUOp;
    logic [2:0]       Funct;
    logic [2:0]       Opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             ovf;
    logic             illegal;
    logic [3:0]       alu_ctrl;

    modport master (
        output in_valid, ALUOp, Funct, Opcode, a, b, out_ready,
        input  in_ready, out_valid, result, zero, ovf, illegal, alu_ctrl
    );

    modport slave (
        input  in_valid, ALUOp, Funct, Opcode, a, b, out_ready,
        output in_ready, out_valid, result, zero, ovf, illegal, alu_ctrl
    );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: handshaked ALU with iterative unsigned divide/remainder.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   bus          alu_exec_if slave (request in, result out)
//   o_dbg_state  current FSM state (IDLE=0, DIV=1, DONE=2)
//
// Single-cycle ops are computed combinationally and captured on accept.
// DIV/REM run a restoring division, one quotient bit per cycle, MSB first.
module alu_exec_unit #(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_exec_if.slave  bus,
    output logic [1:0] o_dbg_state
);
    localparam int CW = $clog2(WIDTH);
    localparam int M  = WIDTH - 1;

    localparam logic [3:0] CTRL_AND  = 4'b0000;
    localparam logic [3:0] CTRL_SLT  = 4'b0001;
    localparam logic [3:0] CTRL_OR   = 4'b0010;
    localparam logic [3:0] CTRL_XOR  = 4'b0011;
    localparam logic [3:0] CTRL_ADD  = 4'b0100;
    localparam logic [3:0] CTRL_ADDI = 4'b0101;
    localparam logic [3:0] CTRL_DIV  = 4'b0111;
    localparam logic [3:0] CTRL_REM  = 4'b1000;
    localparam logic [3:0] CTRL_SUB  = 4'b1100;
    localparam logic [3:0] CTRL_ILL  = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state, w_state_next;
    logic [WIDTH-1:0] r_result;
    logic             r_zero, r_ovf, r_illegal;
    logic [3:0]       r_ctrl, r_div_ctrl;
    logic [WIDTH-1:0] r_quo;      // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_rem;
    logic [CW-1:0]    r_cnt;

    logic [3:0]       w_ctrl;
    logic             w_illegal, w_is_div, w_ovf;
    logic [WIDTH-1:0] w_res, w_sum, w_diff;
    logic             w_in_ready, w_accept;
    logic [WIDTH:0]   w_rem_shift, w_rem_sub;
    logic             w_fits;
    logic [WIDTH-1:0] w_rem_next, w_quo_next, w_div_res;

    // Decode
    always_comb begin
        w_ctrl    = CTRL_ILL;
        w_illegal = 1'b1;
        case (bus.ALUOp)
            2'b00: begin w_ctrl = CTRL_ADD; w_illegal = 1'b0; end
            2'b01: begin w_ctrl = CTRL_SUB; w_illegal = 1'b0; end
            2'b10: begin
                w_illegal = 1'b0;
                case (bus.Funct)
                    3'b000:  w_ctrl = CTRL_ADD;
                    3'b001:  w_ctrl = CTRL_SUB;
                    3'b010:  w_ctrl = CTRL_AND;
                    3'b011:  w_ctrl = CTRL_OR;
                    3'b100:  w_ctrl = CTRL_XOR;
                    3'b101:  w_ctrl = CTRL_SLT;
                    3'b110:  w_ctrl = CTRL_DIV;
                    default: w_ctrl = CTRL_REM;
                endcase
            end
            default: begin
                case (bus.Opcode)
                    3'b011:  begin w_ctrl = CTRL_ADDI; w_illegal = 1'b0; end
                    3'b001:  begin w_ctrl = CTRL_AND;  w_illegal = 1'b0; end
                    3'b010:  begin w_ctrl = CTRL_OR;   w_illegal = 1'b0; end
                    3'b100:  begin w_ctrl = CTRL_SLT;  w_illegal = 1'b0; end
                    default: begin w_ctrl = CTRL_ILL;  w_illegal = 1'b1; end
                endcase
            end
        endcase
    end

    assign w_is_div = (w_ctrl == CTRL_DIV) || (w_ctrl == CTRL_REM);
    assign w_sum    = bus.a + bus.b;
    assign w_diff   = bus.a - bus.b;

    // Single-cycle datapath; illegal falls to the default (result 0)
    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        case (w_ctrl)
            CTRL_ADD, CTRL_ADDI: begin
                w_res = w_sum;
                w_ovf = (bus.a[M] == bus.b[M]) && (w_sum[M] != bus.a[M]);
            end
            CTRL_SUB: begin
                w_res = w_diff;
                w_ovf = (bus.a[M] != bus.b[M]) && (w_diff[M] != bus.a[M]);
            end
            CTRL_AND: w_res = bus.a & bus.b;
            CTRL_OR:  w_res = bus.a | bus.b;
            CTRL_XOR: w_res = bus.a ^ bus.b;
            CTRL_SLT: w_res = WIDTH'($signed(bus.a) < $signed(bus.b));
            default:  w_res = '0;
        endcase
    end

    // One restoring-division step. With a zero divisor every step "fits",
    // which naturally yields an all-ones quotient and remainder == a.
    assign w_rem_shift = {r_rem, r_quo[M]};
    assign w_rem_sub   = w_rem_shift - {1'b0, r_divisor};
    assign w_fits      = (w_rem_shift >= {1'b0, r_divisor});
    assign w_rem_next  = w_fits ? w_rem_sub[WIDTH-1:0] : w_rem_shift[WIDTH-1:0];
    assign w_quo_next  = {r_quo[WIDTH-2:0], w_fits};
    assign w_div_res   = (r_div_ctrl == CTRL_REM) ? w_rem_next : w_quo_next;

    assign w_in_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;

    // FSM next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept)
                    w_state_next = w_is_div ? S_DIV : S_DONE;
                else if ((r_state == S_DONE) && bus.out_ready)
                    w_state_next = S_IDLE;
            end
            S_DIV: begin
                if (r_cnt == '0)
                    w_state_next = S_DONE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_result   <= '0;
            r_zero     <= 1'b1;
            r_ovf      <= 1'b0;
            r_illegal  <= 1'b0;
            r_ctrl     <= 4'b0000;
            r_div_ctrl <= 4'b0000;
            r_quo      <= '0;
            r_divisor  <= '0;
            r_rem      <= '0;
            r_cnt      <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_DIV) begin
                r_quo <= w_quo_next;
                r_rem <= w_rem_next;
                r_cnt <= r_cnt - CW'(1);
                if (r_cnt == '0) begin
                    r_result  <= w_div_res;
                    r_zero    <= (w_div_res == '0);
                    r_ovf     <= 1'b0;
                    r_illegal <= 1'b0;
                    r_ctrl    <= r_div_ctrl;
                end
            end else if (w_accept) begin
                if (w_is_div) begin
                    // Result registers keep the previous value until completion
                    r_quo      <= bus.a;
                    r_divisor  <= bus.b;
                    r_rem      <= '0;
                    r_cnt      <= CW'(WIDTH - 1);
                    r_div_ctrl <= w_ctrl;
                end else begin
                    r_result  <= w_res;
                    r_zero    <= (w_res == '0);
                    r_ovf     <= w_ovf;
                    r_illegal <= w_illegal;
                    r_ctrl    <= w_ctrl;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.ovf       = r_ovf;
    assign bus.illegal   = r_illegal;
    assign bus.alu_ctrl  = r_ctrl;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;
    localparam int W = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_state;

    alu_exec_if #(.WIDTH(W)) bus_if ();

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus_if),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [W-1:0] res;
        logic         zero;
        logic         ovf;
        logic         ill;
        logic [3:0]   ctrl;
        int           lat;
    } exp_t;

    function automatic exp_t model(input logic [1:0] op, input logic [2:0] f,
                                   input logic [2:0] oc, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t  m;
        string kind;
        int    sa, sb, r;
        int    smax, smin;
        smax = (1 << (W - 1)) - 1;
        smin = -(1 << (W - 1));
        sa = $signed(a);
        sb = $signed(b);
        m.ill = 1'b0;
        m.ovf = 1'b0;
        m.lat = 1;
        m.res = '0;
        kind = "ill";
        m.ctrl = 4'b1111;
        if (op == 2'b00) begin kind = "add"; m.ctrl = 4'b0100; end
        else if (op == 2'b01) begin kind = "sub"; m.ctrl = 4'b1100; end
        else if (op == 2'b10) begin
            case (f)
                3'd0: begin kind = "add"; m.ctrl = 4'b0100; end
                3'd1: begin kind = "sub"; m.ctrl = 4'b1100; end
                3'd2: begin kind = "and"; m.ctrl = 4'b0000; end
                3'd3: begin kind = "or";  m.ctrl = 4'b0010; end
                3'd4: begin kind = "xor"; m.ctrl = 4'b0011; end
                3'd5: begin kind = "slt"; m.ctrl = 4'b0001; end
                3'd6: begin kind = "div"; m.ctrl = 4'b0111; end
                default: begin kind = "rem"; m.ctrl = 4'b1000; end
            endcase
        end else begin
            case (oc)
                3'd3: begin kind = "add"; m.ctrl = 4'b0101; end
                3'd1: begin kind = "and"; m.ctrl = 4'b0000; end
                3'd2: begin kind = "or";  m.ctrl = 4'b0010; end
                3'd4: begin kind = "slt"; m.ctrl = 4'b0001; end
                default: begin kind = "ill"; m.ctrl = 4'b1111; end
            endcase
        end
        case (kind)
            "add": begin r = sa + sb; m.res = r[W-1:0]; m.ovf = (r > smax) || (r < smin); end
            "sub": begin r = sa - sb; m.res = r[W-1:0]; m.ovf = (r > smax) || (r < smin); end
            "and": m.res = a & b;
            "or":  m.res = a | b;
            "xor": m.res = a ^ b;
            "slt": m.res = (sa < sb) ? W'(1) : W'(0);
            "div": begin m.lat = W + 1; m.res = (b == 0) ? {W{1'b1}} : a / b; end
            "rem": begin m.lat = W + 1; m.res = (b == 0) ? a : a % b; end
            default: begin m.ill = 1'b1; m.res = '0; end
        endcase
        m.zero = (m.res == 0);
        return m;
    endfunction

    // ---------------- driver ----------------
    // Called and returns on a falling edge. On return out_valid is high
    // (unless the bound expired) and out_ready is high.
    task automatic run_op(input logic [1:0] op, input logic [2:0] f, input logic [2:0] oc,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int busy);
        int guard;
        guard = 0;
        bus_if.ALUOp     = op;
        bus_if.Funct     = f;
        bus_if.Opcode    = oc;
        bus_if.a         = a;
        bus_if.b         = b;
        bus_if.in_valid  = 1'b1;
        bus_if.out_ready = 1'b1;
        #1;
        while (!bus_if.in_ready && guard < 200) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (guard >= 200) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        lat  = 1;
        busy = 0;
        while (!bus_if.out_valid && lat < 200) begin
            if (!bus_if.in_ready) busy++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_out_valid"}, bus_if.out_valid, 1'b0);
        check({tag, "_result"},    bus_if.result, 16'h0000);
        check({tag, "_zero"},      bus_if.zero, 1'b1);
        check({tag, "_ovf"},       bus_if.ovf, 1'b0);
        check({tag, "_illegal"},   bus_if.illegal, 1'b0);
        check({tag, "_alu_ctrl"},  bus_if.alu_ctrl, 4'b0000);
        check({tag, "_in_ready"},  bus_if.in_ready, 1'b1);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [1:0]   op;
        logic [2:0]   funct;
        logic [2:0]   opcode;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_res;
        logic         exp_zero;
        logic         exp_ovf;
        logic         exp_ill;
        logic [3:0]   exp_ctrl;
        int           exp_lat;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs[NV];

    initial begin
        int lat, busy;
        exp_t m;
        logic [W-1:0] ra, rb;
        logic [1:0]   rop;
        logic [2:0]   rf, roc;
        logic [W-1:0] corners[5];

        vecs[0]  = '{2'b00, 3'd0, 3'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 4'b0100, 1};
        vecs[1]  = '{2'b10, 3'd1, 3'd0, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b0, 4'b1100, 1};
        vecs[2]  = '{2'b10, 3'd5, 3'd0, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 4'b0001, 1};
        vecs[3]  = '{2'b11, 3'd0, 3'd7, 16'h1234, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b1, 4'b1111, 1};
        vecs[4]  = '{2'b11, 3'd0, 3'd3, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0, 1'b0, 4'b0101, 1};
        vecs[5]  = '{2'b01, 3'd0, 3'd0, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0, 4'b1100, 1};
        vecs[6]  = '{2'b10, 3'd2, 3'd0, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 1'b0, 4'b0000, 1};
        vecs[7]  = '{2'b10, 3'd4, 3'd0, 16'hAAAA, 16'h5555, 16'hFFFF, 1'b0, 1'b0, 1'b0, 4'b0011, 1};
        vecs[8]  = '{2'b11, 3'd0, 3'd2, 16'h00F0, 16'h000F, 16'h00FF, 1'b0, 1'b0, 1'b0, 4'b0010, 1};
        vecs[9]  = '{2'b11, 3'd0, 3'd4, 16'h0001, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 4'b0001, 1};
        vecs[10] = '{2'b10, 3'd0, 3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 4'b0100, 1};
        vecs[11] = '{2'b11, 3'd0, 3'd1, 16'h1234, 16'h00FF, 16'h0034, 1'b0, 1'b0, 1'b0, 4'b0000, 1};
        vecs[12] = '{2'b10, 3'd6, 3'd0, 16'd100,  16'd7,    16'd14,   1'b0, 1'b0, 1'b0, 4'b0111, 17};
        vecs[13] = '{2'b10, 3'd7, 3'd0, 16'd100,  16'd7,    16'd2,    1'b0, 1'b0, 1'b0, 4'b1000, 17};
        vecs[14] = '{2'b10, 3'd6, 3'd0, 16'd100,  16'd0,    16'hFFFF, 1'b0, 1'b0, 1'b0, 4'b0111, 17};
        vecs[15] = '{2'b10, 3'd7, 3'd0, 16'h1234, 16'd0,    16'h1234, 1'b0, 1'b0, 1'b0, 4'b1000, 17};

        corners[0] = 16'h0000; corners[1] = 16'h0001; corners[2] = 16'h7FFF;
        corners[3] = 16'h8000; corners[4] = 16'hFFFF;

        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b0;
        bus_if.ALUOp     = 2'b00;
        bus_if.Funct     = 3'd0;
        bus_if.Opcode    = 3'd0;
        bus_if.a         = '0;
        bus_if.b         = '0;

        // Reset
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("reset");

        // Table-driven vectors
        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].op, vecs[i].funct, vecs[i].opcode, vecs[i].a, vecs[i].b, lat, busy);
            check($sformatf("v%0d_result", i),   bus_if.result,   vecs[i].exp_res);
            check($sformatf("v%0d_zero", i),     bus_if.zero,     vecs[i].exp_zero);
            check($sformatf("v%0d_ovf", i),      bus_if.ovf,      vecs[i].exp_ovf);
            check($sformatf("v%0d_illegal", i),  bus_if.illegal,  vecs[i].exp_ill);
            check($sformatf("v%0d_alu_ctrl", i), bus_if.alu_ctrl, vecs[i].exp_ctrl);
            check($sformatf("v%0d_latency", i),  lat,             vecs[i].exp_lat);
            if (vecs[i].exp_lat > 1)
                check($sformatf("v%0d_busy_cycles", i), busy, W);
        end

        // Stall with out_ready low, then back-to-back ORI
        run_op(2'b10, 3'd4, 3'd0, 16'h0F0F, 16'h00FF, lat, busy);
        check("stall_first_result", bus_if.result, 16'h0FF0);
        bus_if.out_ready = 1'b0;
        bus_if.ALUOp     = 2'b11;
        bus_if.Opcode    = 3'd2;
        bus_if.a         = 16'h00F0;
        bus_if.b         = 16'h000F;
        bus_if.in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("stall%0d_result", k),    bus_if.result, 16'h0FF0);
            check($sformatf("stall%0d_out_valid", k), bus_if.out_valid, 1'b1);
            check($sformatf("stall%0d_in_ready", k),  bus_if.in_ready, 1'b0);
        end
        bus_if.out_ready = 1'b1;
        #1;
        check("b2b_in_ready", bus_if.in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        check("b2b_result",    bus_if.result, 16'h00FF);
        check("b2b_alu_ctrl",  bus_if.alu_ctrl, 4'b0010);
        check("b2b_out_valid", bus_if.out_valid, 1'b1);

        // Reset asserted in the middle of a DIV
        bus_if.ALUOp    = 2'b10;
        bus_if.Funct    = 3'd6;
        bus_if.a        = 16'd1000;
        bus_if.b        = 16'd3;
        bus_if.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("middiv_busy", bus_if.in_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_values("middiv_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("middiv_no_result", bus_if.out_valid, 1'b0);
        run_op(2'b00, 3'd0, 3'd0, 16'd2, 16'd3, lat, busy);
        check("after_reset_add_result",  bus_if.result, 16'd5);
        check("after_reset_add_latency", lat, 1);

        // Randomized stimulus against the reference model
        for (int i = 0; i < 60; i++) begin
            rop = 2'($urandom_range(0, 3));
            rf  = 3'($urandom_range(0, 7));
            roc = 3'($urandom_range(0, 7));
            ra  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : W'($urandom);
            rb  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : W'($urandom);
            m = model(rop, rf, roc, ra, rb);
            exp_q.push_back(m.res);
            run_op(rop, rf, roc, ra, rb, lat, busy);
            check($sformatf("rnd%0d_result", i),   bus_if.result, exp_q.pop_front());
            check($sformatf("rnd%0d_zero", i),     bus_if.zero, m.zero);
            check($sformatf("rnd%0d_ovf", i),      bus_if.ovf, m.ovf);
            check($sformatf("rnd%0d_illegal", i),  bus_if.illegal, m.ill);
            check($sformatf("rnd%0d_alu_ctrl", i), bus_if.alu_ctrl, m.ctrl);
            check($sformatf("rnd%0d_latency", i),  lat, m.lat);
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
